// File: rtl/fitness_evaluator.sv
// Applies stored test vectors to an evolved circuit, waits for it to settle, and
// counts masked output-bit mismatches per output; results returned via start/done/feedback.
module fitness_evaluator #(
  parameter int MAX_SEQ       = 32,
  parameter int IN_W          = 32,
  parameter int NUM_OUT       = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset,
  input  logic                    start_processing_chrom,
  input  logic                    done_processing_feedback,
  input  logic [31:0]             sequences_to_process,
  input  logic [MAX_SEQ*IN_W-1:0] input_sequence_flat,
  input  logic [MAX_SEQ*32-1:0]   expected_output_flat,
  input  logic [MAX_SEQ*32-1:0]   valid_output_flat,
  input  logic [NUM_OUT-1:0]      circuit_output,
  output logic [IN_W-1:0]         circuit_input,
  output logic                    ready_to_process,
  output logic                    done_processing_chrom,
  output logic [NUM_OUT*32-1:0]   error_sum_flat
);

  localparam int IDX_W = (MAX_SEQ > 1) ? $clog2(MAX_SEQ) : 1;
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IN_W-1:0]    cin_q, cin_d;
  logic [31:0]        sum_q [NUM_OUT];
  logic [31:0]        sum_d [NUM_OUT];
  logic [NUM_OUT-1:0] exp_word;
  logic [NUM_OUT-1:0] valid_word;
  logic [NUM_OUT-1:0] err_vec;

  // Only the low NUM_OUT bits of each expected/valid word are evaluated.
  logic unused_flat;
  assign unused_flat = ^{expected_output_flat, valid_output_flat};

  assign exp_word   = expected_output_flat[32'(idx_q) * 32 +: NUM_OUT];
  assign valid_word = valid_output_flat[32'(idx_q) * 32 +: NUM_OUT];
  assign err_vec    = (circuit_output ^ exp_word) & valid_word;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    cin_d   = cin_q;
    for (int b = 0; b < NUM_OUT; b++) sum_d[b] = sum_q[b];

    case (state_q)
      S_IDLE: begin
        if (start_processing_chrom && !done_processing_feedback) begin
          for (int b = 0; b < NUM_OUT; b++) sum_d[b] = '0;
          idx_d = '0;
          if (sequences_to_process == 32'd0) begin
            state_d = S_DONE;
          end else begin
            // Store N_eff-1 so a full MAX_SEQ run fits the index width.
            if (sequences_to_process >= 32'(MAX_SEQ)) last_d = IDX_W'(MAX_SEQ - 1);
            else                                      last_d = IDX_W'(sequences_to_process - 32'd1);
            state_d = S_APPLY;
          end
        end
      end
      S_APPLY: begin
        cin_d   = input_sequence_flat[32'(idx_q) * IN_W +: IN_W];
        cnt_d   = CNT_W'(SETTLE_CYCLES);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q <= CNT_W'(1)) state_d = S_SAMPLE;
        else                    cnt_d   = cnt_q - CNT_W'(1);
      end
      S_SAMPLE: begin
        for (int b = 0; b < NUM_OUT; b++) sum_d[b] = sum_q[b] + 32'(err_vec[b]);
        if (idx_q == last_q) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_APPLY;
        end
      end
      S_DONE: begin
        if (done_processing_feedback) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      cin_q   <= '0;
      for (int b = 0; b < NUM_OUT; b++) sum_q[b] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      cin_q   <= cin_d;
      for (int b = 0; b < NUM_OUT; b++) sum_q[b] <= sum_d[b];
    end
  end

  assign circuit_input         = cin_q;
  assign ready_to_process      = (state_q == S_IDLE);
  assign done_processing_chrom = (state_q == S_DONE);

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_sum_out
    assign error_sum_flat[g*32 +: 32] = sum_q[g];
  end

endmodule

// File: tb/tb_fitness_evaluator.sv
// Scoreboard bench for fitness_evaluator: a behavioural echo circuit with a
// flip mask stands in for the evolved circuit; expected sums/latency are queued per run.
module tb_fitness_evaluator;

  localparam int MAX_SEQ = 32;
  localparam int IN_W    = 32;
  localparam int NUM_OUT = 8;
  localparam int SETTLE  = 4;

  typedef struct {
    logic [NUM_OUT*32-1:0] sums;
    int                    lat;
    logic [IN_W-1:0]       ci;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic                    feedback;
  logic [31:0]             n_seq;
  logic [MAX_SEQ*IN_W-1:0] in_flat;
  logic [MAX_SEQ*32-1:0]   exp_flat;
  logic [MAX_SEQ*32-1:0]   val_flat;
  logic [NUM_OUT-1:0]      cout;
  logic [IN_W-1:0]         cin;
  logic                    ready;
  logic                    done;
  logic [NUM_OUT*32-1:0]   sums_out;

  logic [IN_W-1:0]    vec  [MAX_SEQ];
  logic [31:0]        expw [MAX_SEQ];
  logic [31:0]        valw [MAX_SEQ];
  logic [NUM_OUT-1:0] flip;
  logic [IN_W-1:0]    last_ci;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < MAX_SEQ; i++) begin
      in_flat[i*IN_W +: IN_W] = vec[i];
      exp_flat[i*32 +: 32]    = expw[i];
      val_flat[i*32 +: 32]    = valw[i];
    end
  end

  assign cout = cin[NUM_OUT-1:0] ^ flip;

  fitness_evaluator #(
    .MAX_SEQ(MAX_SEQ), .IN_W(IN_W), .NUM_OUT(NUM_OUT), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk_clk                 (clk),
    .reset_reset             (rst),
    .start_processing_chrom  (start),
    .done_processing_feedback(feedback),
    .sequences_to_process    (n_seq),
    .input_sequence_flat     (in_flat),
    .expected_output_flat    (exp_flat),
    .valid_output_flat       (val_flat),
    .circuit_output          (cout),
    .circuit_input           (cin),
    .ready_to_process        (ready),
    .done_processing_chrom   (done),
    .error_sum_flat          (sums_out)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic check_sums(input string tag, input logic [NUM_OUT*32-1:0] want);
    for (int b = 0; b < NUM_OUT; b++)
      check_val($sformatf("%s_sum%0d", tag, b), 64'(sums_out[b*32 +: 32]), 64'(want[b*32 +: 32]));
  endtask

  // Reference: each output is the echoed input bit xor flip, compared with expected under mask.
  function automatic exp_t model(input int n);
    exp_t e;
    int   ne;
    ne     = (n > MAX_SEQ) ? MAX_SEQ : n;
    e.sums = '0;
    e.lat  = ne * (SETTLE + 2);
    e.ci   = (ne > 0) ? vec[ne-1] : last_ci;
    for (int i = 0; i < ne; i++)
      for (int b = 0; b < NUM_OUT; b++)
        if (((vec[i][b] ^ flip[b]) ^ expw[i][b]) & valw[i][b])
          e.sums[b*32 +: 32] = e.sums[b*32 +: 32] + 32'd1;
    return e;
  endfunction

  task automatic run(input string tag, input int n);
    exp_t e;
    int   cyc;
    @(negedge clk);
    n_seq = 32'(n);
    sb.push_back(model(n));
    start    = 1'b1;
    feedback = 1'b0;
    @(posedge clk);
    cyc = 0;
    forever begin
      @(negedge clk);
      if (done) break;
      if (cyc > 400) begin
        check_val({tag, "_timeout"}, 64'(done), 64'd1);
        break;
      end
      @(posedge clk);
      cyc++;
    end
    e = sb.pop_front();
    check_val({tag, "_latency"}, 64'(cyc), 64'(e.lat));
    check_val({tag, "_ready_low"}, 64'(ready), 64'd0);
    check_val({tag, "_cin"}, 64'(cin), 64'(e.ci));
    check_sums(tag, e.sums);
    last_ci = e.ci;
    feedback = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_val({tag, "_done_fall"}, 64'(done), 64'd0);
    check_val({tag, "_ready_back"}, 64'(ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    check_val({tag, "_no_reaccept"}, 64'(ready), 64'd1);
    start    = 1'b0;
    feedback = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_sums({tag, "_held"}, e.sums);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; feedback = 1'b0; n_seq = '0; flip = '0; last_ci = '0;
    for (int i = 0; i < MAX_SEQ; i++) begin
      vec[i] = '0; expw[i] = '0; valw[i] = 32'hFF;
    end
    #12;
    check_val("rst_ready", 64'(ready), 64'd1);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_cin", 64'(cin), 64'd0);
    check_sums("rst", '0);
    @(negedge clk);
    rst = 1'b0;

    // Single matching vector.
    vec[0] = 32'hA5; expw[0] = 32'hA5; valw[0] = 32'hFF; flip = '0;
    run("t1", 1);

    // Three vectors, bit0 wrong every time.
    for (int i = 0; i < 3; i++) begin
      vec[i] = $urandom; expw[i] = {24'h0, vec[i][7:0]}; valw[i] = 32'hFF;
    end
    flip = 8'h01;
    run("t2", 3);

    // Restart after a nonzero run must begin from zero.
    vec[0] = 32'hA5; expw[0] = 32'hA5; flip = '0;
    run("t5", 1);

    // Vector 1 masks bit0.
    for (int i = 0; i < 3; i++) begin
      vec[i] = $urandom; expw[i] = {24'h0, vec[i][7:0]}; valw[i] = 32'hFF;
    end
    valw[1] = 32'hFE; flip = 8'h01;
    run("t3", 3);

    run("t4_zero", 0);

    // Oversized N clamps to MAX_SEQ; random data exercises all bits.
    for (int i = 0; i < MAX_SEQ; i++) begin
      vec[i] = $urandom; expw[i] = $urandom; valw[i] = $urandom;
    end
    flip = 8'h5C;
    run("t4_clamp", 40);

    // Reset during SETTLE of the third vector.
    for (int i = 0; i < 3; i++) begin
      vec[i] = 32'h100 | i; expw[i] = {24'h0, vec[i][7:0]}; valw[i] = 32'hFF;
    end
    flip = 8'h01;
    @(negedge clk);
    n_seq = 32'd3; start = 1'b1;
    @(posedge clk);
    repeat (14) @(posedge clk);
    @(negedge clk);
    check_val("t6_pre_sum0", 64'(sums_out[31:0]), 64'd2);
    check_val("t6_pre_cin", 64'(cin), 64'h102);
    rst = 1'b1;
    #1;
    check_val("t6_ready", 64'(ready), 64'd1);
    check_val("t6_done", 64'(done), 64'd0);
    check_val("t6_cin", 64'(cin), 64'd0);
    check_sums("t6", '0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_ci = '0;

    vec[0] = 32'h3C; expw[0] = 32'h3C; flip = 8'h80;
    run("t7_recover", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
